piezo_seq: RTL



---
 rtl/piezo_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/piezo_seq.sv
// rtl/piezo_seq.sv - tune sequencer and alert arbiter driving the piezo tone generator
module piezo_seq #(
    parameter logic        FAST_SIM = 1'b1,
    parameter logic [27:0] RPT_CNT  = 28'h8F0D180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        too_fast,
    input  logic        batt_low,
    input  logic        en_steer,
    input  logic        tone_rdy,
    input  logic        tone_done,
    output logic        tone_start,
    output logic [14:0] tone_prd,
    output logic [24:0] tone_dur,
    output logic [1:0]  tune_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        PLAY  = 2'd2
    } state_t;

    localparam logic [1:0]  TUNE_NONE  = 2'd0;
    localparam logic [1:0]  TUNE_FAST  = 2'd1;
    localparam logic [1:0]  TUNE_BATT  = 2'd2;
    localparam logic [1:0]  TUNE_STEER = 2'd3;
    localparam logic [27:0] INC        = FAST_SIM ? 28'd64 : 28'd1;

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [1:0]  tune_nxt;
    logic [27:0] rpt_cntr;
    logic        rpt_pend;
    logic        enter_issue;
    logic        pend_clr;
    logic        start_nxt;

    function automatic logic [14:0] note_prd(input logic [2:0] i);
        case (i)
            3'd0:    note_prd = 15'h7C90;
            3'd1:    note_prd = 15'h5D51;
            3'd2:    note_prd = 15'h4A11;
            3'd3:    note_prd = 15'h3E48;
            3'd4:    note_prd = 15'h4A11;
            3'd5:    note_prd = 15'h3E48;
            default: note_prd = 15'h0000;
        endcase
    endfunction

    function automatic logic [24:0] note_dur(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: note_dur = 25'h07FFFFF;
            3'd3:             note_dur = 25'h0BFFFFF;
            3'd4:             note_dur = 25'h03FFFFF;
            3'd5:             note_dur = 25'h1FFFFFF;
            default:          note_dur = 25'h0000000;
        endcase
    endfunction

    // Repeat timer: a threshold hit in the same cycle as a selection keeps rpt_pend set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cntr <= 28'd0;
            rpt_pend <= 1'b0;
        end else if (rpt_cntr >= RPT_CNT) begin
            rpt_cntr <= 28'd0;
            rpt_pend <= 1'b1;
        end else begin
            rpt_cntr <= rpt_cntr + INC;
            if (pend_clr) begin
                rpt_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        tune_nxt    = tune_id;
        enter_issue = 1'b0;
        pend_clr    = 1'b0;
        start_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (too_fast) begin
                    tune_nxt    = TUNE_FAST;
                    idx_nxt     = 3'd0;
                    enter_issue = 1'b1;
                end else if (batt_low && rpt_pend) begin
                    tune_nxt    = TUNE_BATT;
                    idx_nxt     = 3'd5;
                    enter_issue = 1'b1;
                end else if (en_steer && rpt_pend) begin
                    tune_nxt    = TUNE_STEER;
                    idx_nxt     = 3'd0;
                    enter_issue = 1'b1;
                end
                pend_clr = enter_issue;
            end
            ISSUE: begin
                if (tone_rdy) begin
                    state_nxt = PLAY;
                    start_nxt = 1'b1;
                end
            end
            PLAY: begin
                // A done coinciding with our own start pulse belongs to the previous note.
                if (tone_done && !tone_start) begin
                    state_nxt = IDLE;
                    tune_nxt  = TUNE_NONE;
                    if (too_fast && tune_id != TUNE_FAST) begin
                        tune_nxt    = TUNE_FAST;
                        idx_nxt     = 3'd0;
                        enter_issue = 1'b1;
                    end else begin
                        case (tune_id)
                            TUNE_FAST: begin
                                if (too_fast) begin
                                    tune_nxt    = TUNE_FAST;
                                    idx_nxt     = (idx == 3'd2) ? 3'd0 : idx + 3'd1;
                                    enter_issue = 1'b1;
                                end
                            end
                            TUNE_STEER: begin
                                if (idx != 3'd5) begin
                                    tune_nxt    = TUNE_STEER;
                                    idx_nxt     = idx + 3'd1;
                                    enter_issue = 1'b1;
                                end
                            end
                            TUNE_BATT: begin
                                if (idx != 3'd0) begin
                                    tune_nxt    = TUNE_BATT;
                                    idx_nxt     = idx - 3'd1;
                                    enter_issue = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tune_nxt  = TUNE_NONE;
            end
        endcase
        if (enter_issue) begin
            state_nxt = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            tune_id    <= TUNE_NONE;
            tone_start <= 1'b0;
            tone_prd   <= 15'd0;
            tone_dur   <= 25'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tune_id    <= tune_nxt;
            tone_start <= start_nxt;
            if (enter_issue) begin
                tone_prd <= note_prd(idx_nxt);
                tone_dur <= note_dur(idx_nxt);
            end else if (state_nxt == IDLE) begin
                tone_prd <= 15'd0;
                tone_dur <= 25'd0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
